// File: rtl/cyclic_divider_pkg.sv
// Shared types and helpers for the cyclic restoring divider.
package cyclic_divider_pkg;

    typedef enum logic {IDLE, CALC} state_t;

    // Width of the step counter for a W-bit division.
    function automatic int CNT_W(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/cyclic_div_control.sv
// FSM and step counter for the cyclic divider; load restarts from any state.
module cyclic_div_control
    import cyclic_divider_pkg::*;
#(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic valid,
    output logic calc,
    output logic last_step
);

    localparam int CW = CNT_W(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b1;
            calc  <= 1'b0;
        end else if (load) begin
            state <= CALC;
            cnt   <= '0;
            valid <= 1'b0;
            calc  <= 1'b1;
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
                state <= IDLE;
                valid <= 1'b1;
                calc  <= 1'b0;
            end
        end
    end

    assign last_step = calc && (cnt == LAST);

endmodule

// File: rtl/prop_adder.sv
// Generic W-bit adder with carry-in and carry-out.
module prop_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/cyclic_divider.sv
// Sequential restoring divider: W-bit quotient and remainder in W cycles.
module cyclic_divider
    import cyclic_divider_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         valid,
    output logic         div_by_zero
);

    logic [W-1:0] r_reg;
    logic [W-1:0] q_reg;
    logic [W-1:0] d_reg;
    logic         dbz_reg;
    logic         calc;
    logic         last_step;
    logic [W:0]   trial;
    logic         no_borrow;
    logic         unused_trial_msb;
    logic         unused_last_step;

    cyclic_div_control #(.W(W)) u_control (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .valid     (valid),
        .calc      (calc),
        .last_step (last_step)
    );

    // Trial subtraction {R, Q msb} - D as an add of ~D with carry-in; carry-out means no borrow.
    prop_adder #(.W(W + 1)) u_adder (
        .a    ({r_reg, q_reg[W-1]}),
        .b    (~{1'b0, d_reg}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (no_borrow)
    );

    assign unused_trial_msb = trial[W];
    assign unused_last_step = last_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg   <= '0;
            q_reg   <= '0;
            d_reg   <= '0;
            dbz_reg <= 1'b0;
        end else if (load) begin
            r_reg   <= '0;
            q_reg   <= dividend;
            d_reg   <= divisor;
            dbz_reg <= (divisor == '0);
        end else if (calc) begin
            if (no_borrow) begin
                r_reg <= trial[W-1:0];
                q_reg <= {q_reg[W-2:0], 1'b1};
            end else begin
                r_reg <= {r_reg[W-2:0], q_reg[W-1]};
                q_reg <= {q_reg[W-2:0], 1'b0};
            end
        end
    end

    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_cyclic_divider.sv
// Scoreboard bench for cyclic_divider: directed cases, abort, reset and a full operand sweep.
module tb_cyclic_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    cyclic_divider #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .valid       (valid),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Load one division; a new load supersedes any result still pending.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        load     = 1'b1;
        dividend = a;
        divisor  = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        sb.delete();
        sb.push_back(e);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Called #1 after the load edge; counts edges until valid rises, then checks the result.
    task automatic waitResult(input string tag);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (cycles < 3 * W) begin
            @(posedge clk);
            #1;
            cycles++;
            if (valid) break;
        end
        checkOutput({tag, "_latency"}, cycles, W);
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_quotient"}, quotient, e.q);
            checkOutput({tag, "_remainder"}, remainder, e.r);
            checkOutput({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, valid, 1);
        checkOutput({tag, "_quotient"}, quotient, 0);
        checkOutput({tag, "_remainder"}, remainder, 0);
        checkOutput({tag, "_dbz"}, div_by_zero, 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        load         = 1'b0;
        dividend     = '0;
        divisor      = '0;

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("idle");

        applyStimulus(4'd13, 4'd3);
        waitResult("div13_3");
        applyStimulus(4'd15, 4'd1);
        waitResult("div15_1");
        applyStimulus(4'd2, 4'd7);
        waitResult("div2_7");
        applyStimulus(4'd0, 4'd5);
        waitResult("div0_5");
        applyStimulus(4'd5, 4'd0);
        waitResult("div5_0");
        applyStimulus(4'd6, 4'd3);
        waitResult("div6_3");

        // Abort: second load two cycles after the first.
        applyStimulus(4'd13, 4'd3);
        @(posedge clk);
        #1;
        checkOutput("abort_valid_low", valid, 0);
        applyStimulus(4'd9, 4'd2);
        waitResult("abort9_2");

        // Reset mid-division overrides a simultaneous load.
        applyStimulus(4'd13, 4'd3);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        load     = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        sb.delete();
        @(posedge clk);
        #1;
        checkResetState("mid_reset");
        rst_n = 1'b1;
        load  = 1'b0;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(4'(a), 4'(b));
                waitResult("sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
